// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction-fetch sequencer.
package fetch_pkg;

  localparam int ADDR_W_DEF  = 8;
  localparam int INSTR_W_DEF = 16;
  localparam int PC_STEP     = 2;
  localparam logic [ADDR_W_DEF-1:0] RESET_PC_DEF = 8'h00;

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/fetch_buf.sv
// Two-entry FIFO of {instr, pc}; entry 0 is always the head.
module fetch_buf #(
  parameter int W = 24
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic [1:0]   count
);

  logic [W-1:0] e0_q, e0_d;
  logic [W-1:0] e1_q, e1_d;
  logic [1:0]   cnt_q, cnt_d;
  logic         do_pop;
  logic         do_push;

  assign do_pop  = pop && (cnt_q != 2'd0);
  // A push into a full buffer is only legal when the head leaves in the same cycle.
  assign do_push = push && ((cnt_q != 2'd2) || do_pop);

  always_comb begin
    e0_d  = e0_q;
    e1_d  = e1_q;
    cnt_d = cnt_q;
    if (flush) begin
      cnt_d = 2'd0;
    end else begin
      case ({do_push, do_pop})
        2'b10: begin
          if (cnt_q == 2'd0) e0_d = din;
          else               e1_d = din;
          cnt_d = cnt_q + 2'd1;
        end
        2'b01: begin
          e0_d  = e1_q;
          cnt_d = cnt_q - 2'd1;
        end
        2'b11: begin
          if (cnt_q == 2'd2) begin
            e0_d = e1_q;
            e1_d = din;
          end else begin
            e0_d = din;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e0_q  <= '0;
      e1_q  <= '0;
      cnt_q <= 2'd0;
    end else begin
      e0_q  <= e0_d;
      e1_q  <= e1_d;
      cnt_q <= cnt_d;
    end
  end

  assign dout  = (cnt_q != 2'd0) ? e0_q : '0;
  assign count = cnt_q;

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch sequencer: owns the fetch PC, fills fetch_buf from imem and handles redirect/halt.
// Decode handshake: a transfer happens in every cycle where if_valid && id_ready are both high.
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int                ADDR_W   = ADDR_W_DEF,
  parameter int                INSTR_W  = INSTR_W_DEF,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEF)
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic [ADDR_W-1:0]  imem_addr,
  output logic               imem_en,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               if_valid,
  output logic [INSTR_W-1:0] if_instr,
  output logic [ADDR_W-1:0]  if_pc,
  input  logic               id_ready,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  input  logic               halt_req,
  output logic               halted,
  output logic               misalign_err,
  output fetch_state_e       dbg_state_o
);

  fetch_state_e              state_q, state_d;
  logic [ADDR_W-1:0]         pc_q, pc_d;
  logic                      mis_q, mis_d;
  logic                      pop;
  logic                      enq;
  logic                      flush;
  logic [1:0]                count;
  logic [INSTR_W+ADDR_W-1:0] buf_dout;

  assign if_valid = (count != 2'd0) && (state_q != HALTED);
  assign pop      = if_valid && id_ready;
  assign enq      = (state_q == FETCH) && !redirect_valid && !halt_req &&
                    ((count != 2'd2) || pop);

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    mis_d   = 1'b0;
    flush   = 1'b0;
    if (redirect_valid) begin
      state_d = FETCH;
      pc_d    = {redirect_pc[ADDR_W-1:1], 1'b0};
      mis_d   = redirect_pc[0];
      flush   = 1'b1;
    end else begin
      if (enq) pc_d = pc_q + ADDR_W'(PC_STEP);
      case (state_q)
        FETCH:   if (halt_req) state_d = DRAIN;
        // Halt completes on the edge that leaves the buffer empty.
        DRAIN:   if ((count == 2'd0) || ((count == 2'd1) && pop)) state_d = HALTED;
        HALTED:  ;
        default: state_d = FETCH;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FETCH;
      pc_q    <= RESET_PC;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      mis_q   <= mis_d;
    end
  end

  fetch_buf #(
    .W(INSTR_W + ADDR_W)
  ) u_buf (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (enq),
    .pop   (pop),
    .flush (flush),
    .din   ({imem_rdata, pc_q}),
    .dout  (buf_dout),
    .count (count)
  );

  assign imem_addr    = pc_q;
  assign imem_en      = enq;
  assign if_instr     = buf_dout[INSTR_W+ADDR_W-1:ADDR_W];
  assign if_pc        = buf_dout[ADDR_W-1:0];
  assign halted       = (state_q == HALTED);
  assign misalign_err = mis_q;
  assign dbg_state_o  = state_q;

endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
Instruction-fetch sequencer that drives the instruction memory (combinational read, 16-bit instructions, PC step 2) and feeds decode.
- Owns the fetch PC.
- Buffers fetched instructions, tagged with their PC, in a 2-entry queue.
- Presents them to decode over a valid/ready handshake.
- Handles control-flow redirects and halt/resume.

Parameters:
- ADDR_W, 8, width of PC / imem address.
- INSTR_W, 16, instruction width.
- RESET_PC, 8'h00, fetch address after reset. Must be even.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- imem_addr  out  ADDR_W  address to instruction memory; always equals fetch_pc.
- imem_en  out  1  high in cycles whose imem_rdata is captured.
- imem_rdata  in  INSTR_W  combinational read data for imem_addr.
- if_valid  out  1  head of queue is valid.
- if_instr  out  INSTR_W  head instruction.
- if_pc  out  ADDR_W  PC of head instruction.
- id_ready  in  1  decode accepts head; transfer occurs when if_valid && id_ready.
- redirect_valid  in  1  branch/jump/resume request.
- redirect_pc  in  ADDR_W  redirect target.
- halt_req  in  1  stop fetching.
- halted  out  1  FSM in HALTED.
- misalign_err  out  1  one-cycle pulse: accepted redirect_pc had bit0 = 1.

Behaviour:
- Reset (async assert, sync release):
  - fetch_pc = RESET_PC; queue empty; state FETCH.
  - if_valid, halted, misalign_err = 0; if_instr and if_pc = 0.
- FSM states: FETCH, DRAIN, HALTED.
- Definitions:
  - pop = if_valid && id_ready.
  - enq = (state == FETCH) && !redirect_valid && !halt_req && (count < 2 || pop).
- imem_en = enq, combinational.
- On each rising edge with enq:
  - Push {imem_rdata, fetch_pc}.
  - fetch_pc <= fetch_pc + 2, modulo 2^ADDR_W, so max even address wraps to 0.
- Latency:
  - First edge after reset release enqueues the instruction at RESET_PC; if_valid rises at that edge.
  - Sustained throughput is 1 instruction/cycle while id_ready = 1.
- Queue:
  - 2 entries, FIFO order.
  - Simultaneous push and pop is allowed when full.
  - Never overflows: enq is gated.
  - if_instr and if_pc hold their values while if_valid = 1 && id_ready = 0.
- Redirect (any state; highest priority):
  - Queue flushed; fetch_pc <= {redirect_pc[ADDR_W-1:1], 1'b0}; state <= FETCH.
  - A pop in the same cycle counts as a completed transfer.
  - No enqueue in the redirect cycle. The target is enqueued on the next edge, so if_valid is low for exactly one cycle.
  - If redirect_pc[0] = 1: misalign_err = 1 for the following cycle.
- Halt:
  - halt_req in FETCH (no redirect) -> DRAIN; fetch_pc frozen.
  - DRAIN -> HALTED when count == 0, including an empty queue after a final pop.
  - HALTED: halted = 1, imem_en = 0, if_valid = 0.
  - Exit from HALTED only via redirect_valid.
  - halt_req deasserted during DRAIN does not cancel the halt.
- Simultaneous redirect_valid and halt_req: redirect wins; halt_req is re-evaluated next cycle.
- Reset mid-operation: immediate return to reset values, including while in DRAIN/HALTED; queue contents discarded.

Decomposition:
- Shared package fetch_pkg holds:
  - state enum {FETCH, DRAIN, HALTED};
  - INSTR_W and ADDR_W defaults;
  - PC_STEP = 2;
  - RESET_PC.
- One sub-module, fetch_buf: 2-entry synchronous FIFO of {instr, pc}.
  - Ports: push, pop, flush, din, dout, count.
  - Async active-low reset.
- fetch_ctrl holds the FSM, fetch_pc and gating.

Test Plan:
- Stream: reset release, id_ready = 1, memory word at addr N = 16'hA000 | N -> if_pc sequence 00, 02, 04, …; if_instr A000, A002, …; one per cycle from the first edge.
- Backpressure: id_ready = 0 for 5 cycles -> exactly 2 entries held (PC 00, 02); imem_en low after 2 edges; fetch_pc stays 04. Release -> 00, 02, 04 delivered in order with no gaps or duplicates.
- Redirect: redirect_pc = 8'h40 while queue is full -> queue flushed; if_valid low 1 cycle; then if_pc = 40, 42. redirect_pc = 8'h41 -> if_pc = 40 and misalign_err pulses 1 cycle.
- Halt/resume: halt_req with 2 queued -> both delivered, then halted = 1 and imem_en = 0. redirect_pc = 8'h10 -> halted = 0; if_pc = 10 next.
- Wrap: redirect to 8'hFC -> if_pc FC, FE, 00, 02.
- Async reset mid-DRAIN: rst_n low between edges -> if_valid and halted = 0 immediately. After release -> if_pc = 00.
